// File: rtl/out_packet_arbiter.sv
// Outbound packet arbiter: power-on reply (fixed priority), keyboard/mic (round-robin).
// Optional saturating statistics counters enabled by defining OUT_ARB_STATS_EN.
module out_packet_arbiter #(
  parameter int unsigned MIN_GAP = 4,
  parameter int unsigned TIMEOUT = 16383,
  parameter int unsigned TW      = 14
) (
  input  logic        mon_clk,
  input  logic        hw_reset_n,
  input  logic        power_on_req,
  input  logic        kb_valid,
  input  logic        kb_is_mouse,
  input  logic [15:0] kb_data,
  output logic        kb_ack,
  input  logic        mic_valid,
  input  logic [31:0] mic_data,
  output logic        mic_ack,
  output logic [39:0] out_data,
  output logic        out_valid,
  input  logic        out_retrieved,
  output logic        timeout_err,
  output logic        busy
`ifdef OUT_ARB_STATS_EN
  ,
  output logic [15:0] stat_kb_cnt,
  output logic [15:0] stat_mic_cnt,
  output logic [15:0] stat_drop_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;
  typedef enum logic [1:0] {SRC_PO, SRC_KB, SRC_MIC} src_t;

  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LAST = (MIN_GAP > 0) ? TW'(MIN_GAP - 1) : '0;

  state_t        state;
  src_t          cur_src;
  logic [TW-1:0] cnt;
  logic          po_pending;
  logic          last_mic;

  logic          gnt_any;
  src_t          gnt_src;
  logic [39:0]   gnt_data;

  // The raw pulse counts as a request so a pulse landing in IDLE beats a same-cycle kb/mic tie.
  always_comb begin
    gnt_any  = 1'b1;
    gnt_src  = SRC_PO;
    gnt_data = {8'hC0, 32'h0};
    if (po_pending || power_on_req) begin
      gnt_src  = SRC_PO;
      gnt_data = {8'hC0, 32'h0};
    end else if (kb_valid && (!mic_valid || last_mic)) begin
      gnt_src  = SRC_KB;
      gnt_data = {8'hC5, 7'b0, kb_is_mouse, 8'h00, kb_data};
    end else if (mic_valid) begin
      gnt_src  = SRC_MIC;
      gnt_data = {8'hC7, mic_data};
    end else begin
      gnt_any  = 1'b0;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge mon_clk or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      state       <= IDLE;
      cur_src     <= SRC_PO;
      cnt         <= '0;
      po_pending  <= 1'b0;
      last_mic    <= 1'b1;
      out_data    <= '0;
      out_valid   <= 1'b0;
      kb_ack      <= 1'b0;
      mic_ack     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      kb_ack      <= 1'b0;
      mic_ack     <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            state     <= PRESENT;
            cur_src   <= gnt_src;
            out_data  <= gnt_data;
            out_valid <= 1'b1;
            cnt       <= '0;
          end
        end
        PRESENT: begin
          if (out_retrieved || cnt == TO_LAST) begin
            state       <= GAP;
            out_valid   <= 1'b0;
            cnt         <= '0;
            timeout_err <= !out_retrieved;
            case (cur_src)
              SRC_PO:  po_pending <= 1'b0;
              SRC_KB:  kb_ack     <= 1'b1;
              SRC_MIC: mic_ack    <= 1'b1;
              default: ;
            endcase
            if (out_retrieved && cur_src != SRC_PO)
              last_mic <= (cur_src == SRC_MIC);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // Placed after the clear so a pulse coinciding with it is not lost.
      if (power_on_req)
        po_pending <= 1'b1;
    end
  end

`ifdef OUT_ARB_STATS_EN
  always_ff @(posedge mon_clk or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      stat_kb_cnt   <= '0;
      stat_mic_cnt  <= '0;
      stat_drop_cnt <= '0;
    end else begin
      if (kb_ack && stat_kb_cnt != '1)
        stat_kb_cnt <= stat_kb_cnt + 16'd1;
      if (mic_ack && stat_mic_cnt != '1)
        stat_mic_cnt <= stat_mic_cnt + 16'd1;
      if (timeout_err && stat_drop_cnt != '1)
        stat_drop_cnt <= stat_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_out_packet_arbiter.sv
// Directed bench for out_packet_arbiter (MIN_GAP=4, TIMEOUT=20).
module tb_out_packet_arbiter;

  logic        mon_clk = 1'b0;
  logic        hw_reset_n;
  logic        power_on_req;
  logic        kb_valid;
  logic        kb_is_mouse;
  logic [15:0] kb_data;
  logic        kb_ack;
  logic        mic_valid;
  logic [31:0] mic_data;
  logic        mic_ack;
  logic [39:0] out_data;
  logic        out_valid;
  logic        out_retrieved;
  logic        timeout_err;
  logic        busy;
`ifdef OUT_ARB_STATS_EN
  logic [15:0] stat_kb_cnt;
  logic [15:0] stat_mic_cnt;
  logic [15:0] stat_drop_cnt;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [39:0] exp_data;
  logic        seen;

  out_packet_arbiter #(
    .MIN_GAP (4),
    .TIMEOUT (20),
    .TW      (14)
  ) dut (
    .mon_clk       (mon_clk),
    .hw_reset_n    (hw_reset_n),
    .power_on_req  (power_on_req),
    .kb_valid      (kb_valid),
    .kb_is_mouse   (kb_is_mouse),
    .kb_data       (kb_data),
    .kb_ack        (kb_ack),
    .mic_valid     (mic_valid),
    .mic_data      (mic_data),
    .mic_ack       (mic_ack),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_retrieved (out_retrieved),
    .timeout_err   (timeout_err),
    .busy          (busy)
`ifdef OUT_ARB_STATS_EN
    ,
    .stat_kb_cnt   (stat_kb_cnt),
    .stat_mic_cnt  (stat_mic_cnt),
    .stat_drop_cnt (stat_drop_cnt)
`endif
  );

  always #5 mon_clk = ~mon_clk;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge mon_clk);
    #1;
  endtask

  task automatic retrieve();
    out_retrieved = 1'b1;
    tick();
    out_retrieved = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int unsigned n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check(tag, {39'b0, out_valid}, 40'd1);
  endtask

  task automatic do_reset();
    hw_reset_n    = 1'b0;
    power_on_req  = 1'b0;
    kb_valid      = 1'b0;
    kb_is_mouse   = 1'b0;
    kb_data       = '0;
    mic_valid     = 1'b0;
    mic_data      = '0;
    out_retrieved = 1'b0;
    tick();
    tick();
    hw_reset_n = 1'b1;
  endtask

  initial begin
    do_reset();
    check("rst_valid", {39'b0, out_valid}, 40'd0);
    check("rst_busy",  {39'b0, busy}, 40'd0);
    check("rst_data",  out_data, 40'd0);
    check("rst_acks",  {37'b0, kb_ack, mic_ack, timeout_err}, 40'd0);

    // Single keyboard request, retrieval 3 cycles after out_valid
    kb_valid = 1'b1; kb_data = 16'h1234; kb_is_mouse = 1'b0;
    tick();
    check("kb1_valid", {39'b0, out_valid}, 40'd1);
    check("kb1_data",  out_data, 40'hC500001234);
    check("kb1_busy",  {39'b0, busy}, 40'd1);
    tick();
    tick();
    check("kb1_noack", {39'b0, kb_ack}, 40'd0);
    retrieve();
    check("kb1_ack",   {39'b0, kb_ack}, 40'd1);
    check("kb1_drop",  {39'b0, out_valid}, 40'd0);
    kb_data = 16'h00AB; kb_is_mouse = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | out_valid;
    end
    check("gap_low",   {39'b0, seen}, 40'd0);
    check("gap_idle",  {39'b0, busy}, 40'd0);
    tick();
    check("kb2_valid", {39'b0, out_valid}, 40'd1);
    check("kb2_data",  out_data, 40'hC5010000AB);
    kb_valid = 1'b0; kb_data = 16'hFFFF; kb_is_mouse = 1'b0;
    tick();
    check("kb2_hold",  out_data, 40'hC5010000AB);
    check("kb2_hold_v", {39'b0, out_valid}, 40'd1);
    retrieve();
    check("kb2_ack",   {39'b0, kb_ack}, 40'd1);

    // Power-on priority
    do_reset();
    power_on_req = 1'b1;
    kb_valid = 1'b1; kb_data = 16'h5555;
    mic_valid = 1'b1; mic_data = 32'hDEADBEEF;
    tick();
    power_on_req = 1'b0;
    check("po_data", out_data, 40'hC000000000);
    retrieve();
    check("po_noack", {38'b0, kb_ack, mic_ack}, 40'd0);
    wait_valid("pri_kb_valid");
    check("pri_kb_data", out_data, 40'hC500005555);
    retrieve();
    check("pri_kb_ack", {39'b0, kb_ack}, 40'd1);
    kb_valid = 1'b0;
    wait_valid("pri_mic_valid");
    check("pri_mic_data", out_data, 40'hC7DEADBEEF);
    retrieve();
    check("pri_mic_ack", {39'b0, mic_ack}, 40'd1);
    mic_valid = 1'b0;

    // Round-robin over six grants
    kb_valid = 1'b1; kb_data = 16'h1000;
    mic_valid = 1'b1; mic_data = 32'hA0000000;
    for (int i = 0; i < 6; i++) begin
      wait_valid("rr_valid");
      if (i % 2 == 0) exp_data = {8'hC5, 8'h00, 8'h00, kb_data};
      else            exp_data = {8'hC7, mic_data};
      check("rr_data", out_data, exp_data);
      retrieve();
      check("rr_kb_ack",  {39'b0, kb_ack},  {39'b0, (i % 2 == 0)});
      check("rr_mic_ack", {39'b0, mic_ack}, {39'b0, (i % 2 == 1)});
      if (i % 2 == 0) kb_data = kb_data + 16'd1;
      else            mic_data = mic_data + 32'd1;
    end

    // Timeout on a mic packet
    kb_valid = 1'b0;
    mic_data = 32'hCAFEF00D;
    wait_valid("to_valid");
    check("to_data", out_data, 40'hC7CAFEF00D);
    for (int k = 1; k < 20; k++) tick();
    check("to_still_valid", {39'b0, out_valid}, 40'd1);
    check("to_not_yet",     {39'b0, timeout_err}, 40'd0);
    tick();
    check("to_err",   {39'b0, timeout_err}, 40'd1);
    check("to_ack",   {39'b0, mic_ack}, 40'd1);
    check("to_drop",  {39'b0, out_valid}, 40'd0);
    check("to_gap",   {39'b0, busy}, 40'd1);
    mic_valid = 1'b0;
    kb_valid = 1'b1; kb_data = 16'h7777;
    tick();
    check("to_pulse", {38'b0, timeout_err, mic_ack}, 40'd0);
    wait_valid("to_next_valid");
    check("to_next_data", out_data, 40'hC500007777);
    retrieve();
    check("to_next_ack", {39'b0, kb_ack}, 40'd1);
    kb_valid = 1'b0;

    // Retrieval and timeout on the same edge, with a new power-on pulse
    power_on_req = 1'b1;
    tick();
    power_on_req = 1'b0;
    wait_valid("sim_valid");
    check("sim_data", out_data, 40'hC000000000);
    for (int k = 1; k < 20; k++) tick();
    check("sim_pre_valid", {39'b0, out_valid}, 40'd1);
    out_retrieved = 1'b1;
    power_on_req  = 1'b1;
    tick();
    out_retrieved = 1'b0;
    power_on_req  = 1'b0;
    check("sim_no_err", {39'b0, timeout_err}, 40'd0);
    check("sim_drop",   {39'b0, out_valid}, 40'd0);
    check("sim_acks",   {38'b0, kb_ack, mic_ack}, 40'd0);
    wait_valid("po2_valid");
    check("po2_data", out_data, 40'hC000000000);
    retrieve();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | out_valid;
    end
    check("po_cleared", {39'b0, seen}, 40'd0);

    // Reset while presenting
    kb_valid = 1'b1; kb_data = 16'h4242;
    mic_valid = 1'b1; mic_data = 32'h01020304;
    wait_valid("rst_mid_valid");
    check("rst_mid_rr", out_data, 40'hC701020304);
    power_on_req = 1'b1;
    tick();
    power_on_req = 1'b0;
    #2;
    hw_reset_n = 1'b0;
    #1;
    check("arst_valid", {39'b0, out_valid}, 40'd0);
    check("arst_busy",  {39'b0, busy}, 40'd0);
    check("arst_acks",  {37'b0, kb_ack, mic_ack, timeout_err}, 40'd0);
    check("arst_data",  out_data, 40'd0);
`ifdef OUT_ARB_STATS_EN
    check("arst_stats", {8'b0, stat_kb_cnt, stat_mic_cnt}, 40'd0);
    check("arst_drops", {24'b0, stat_drop_cnt}, 40'd0);
`endif
    tick();
    hw_reset_n = 1'b1;
    tick();
    check("post_rst_valid", {39'b0, out_valid}, 40'd1);
    check("post_rst_data",  out_data, 40'hC500004242);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
